// File: rtl/cv32e40p_regfile_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_regfile_pkg
// Shared constants, types and helpers for the scoreboarded register file.
//   - default address width and per-bank word counts
//   - regaddr_t : register address type for the default configuration
//   - bank_words / total_words : word counts for an arbitrary address width
//   - flat_index : maps an architectural address to a flat storage index
//                  (bank select + word), folding the MSB away when there is
//                  no separate FP bank
// -----------------------------------------------------------------------------
package cv32e40p_regfile_pkg;

    localparam int unsigned REGFILE_ADDR_WIDTH = 32'd6;
    localparam int unsigned INT_BANK_WORDS     = 32'd1 << (REGFILE_ADDR_WIDTH - 32'd1);
    localparam int unsigned FP_BANK_WORDS      = INT_BANK_WORDS;

    typedef logic [REGFILE_ADDR_WIDTH-1:0] regaddr_t;

    // Words in one bank: the address MSB is the bank select, the rest the word.
    function automatic int unsigned bank_words(input int unsigned addr_width);
        return 32'd1 << (addr_width - 32'd1);
    endfunction

    // Total storage words: two banks when the FP bank exists, otherwise one.
    function automatic int unsigned total_words(input int unsigned addr_width,
                                                input bit          fp_bank);
        if (fp_bank) begin
            return 32'd2 * bank_words(addr_width);
        end else begin
            return bank_words(addr_width);
        end
    endfunction

    // Flat storage index. Integer words occupy 0..N-1, FP words N..2N-1.
    // Without an FP bank the MSB is ignored so FP addresses alias integer ones.
    function automatic logic [31:0] flat_index(input logic [31:0] addr,
                                               input int unsigned addr_width,
                                               input bit          fp_bank);
        logic [31:0] word_mask;
        logic [31:0] bank_sel;
        word_mask = bank_words(addr_width) - 32'd1;
        bank_sel  = (addr >> (addr_width - 32'd1)) & 32'd1;
        if (fp_bank) begin
            return (bank_sel * bank_words(addr_width)) + (addr & word_mask);
        end else begin
            return addr & word_mask;
        end
    endfunction

endpackage

// File: rtl/cv32e40p_register_file_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// cv32e40p_regfile_scoreboard
// Busy tracking for long-latency destinations of the register file.
// Ports (all addresses are flat storage indices, word 0 is x0):
//   clk, rst          clock, asynchronous active-high reset
//   ridx / rbusy      per read port: index in, busy bit out
//   rsv_valid/rsv_idx reservation request, rsv_ready = accepted this cycle
//   rel_valid/rel_idx release of a busy bit (port-B write-back)
//   flush             clear every busy bit next cycle
//   busy_cnt          registered number of busy words
// -----------------------------------------------------------------------------
module cv32e40p_regfile_scoreboard
    import cv32e40p_regfile_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = INT_BANK_WORDS,
    parameter int unsigned IDX_W      = 32'd5,
    parameter int unsigned NUM_RPORTS = 32'd3,
    parameter int unsigned CNT_W      = 32'd7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RPORTS*IDX_W-1:0] ridx,
    output logic [NUM_RPORTS-1:0]       rbusy,
    input  logic                        rsv_valid,
    input  logic [IDX_W-1:0]            rsv_idx,
    output logic                        rsv_ready,
    input  logic                        rel_valid,
    input  logic [IDX_W-1:0]            rel_idx,
    input  logic                        flush,
    output logic [CNT_W-1:0]            busy_cnt
);

    logic [NUM_WORDS-1:0] busy_r;
    logic [NUM_WORDS-1:0] busy_nxt_s;
    logic [CNT_W-1:0]     busy_cnt_r;
    logic [CNT_W-1:0]     busy_cnt_nxt_s;
    logic                 rsv_accept_s;

    // Reservation handshake: a busy destination (WAW) or a flush refuses it.
    always_comb begin
        rsv_accept_s = 1'b0;
        if (rst) begin
            rsv_accept_s = 1'b0;
        end else begin
            rsv_accept_s = rsv_valid & ~busy_r[rsv_idx] & ~flush;
        end
    end

    // Next busy vector: flush clears all, otherwise release then set so an
    // accepted reservation wins a same-address release. x0 is never busy.
    always_comb begin
        busy_nxt_s = busy_r;
        if (flush) begin
            busy_nxt_s = {NUM_WORDS{1'b0}};
        end else begin
            if (rel_valid) begin
                busy_nxt_s[rel_idx] = 1'b0;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
            if (rsv_accept_s) begin
                busy_nxt_s[rsv_idx] = 1'b1;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Population count of the next busy vector, registered alongside it.
    always_comb begin
        busy_cnt_nxt_s = {CNT_W{1'b0}};
        for (int i = 0; i < int'(NUM_WORDS); i++) begin
            busy_cnt_nxt_s = busy_cnt_nxt_s + CNT_W'(busy_nxt_s[i]);
        end
    end

    // Busy vector and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= {NUM_WORDS{1'b0}};
            busy_cnt_r <= {CNT_W{1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= busy_cnt_nxt_s;
        end
    end

    // Per-port busy lookup; reflects the registered state, so a same-cycle
    // release is only visible next cycle.
    always_comb begin
        rbusy = {NUM_RPORTS{1'b0}};
        for (int p = 0; p < int'(NUM_RPORTS); p++) begin
            if (rst) begin
                rbusy[p] = 1'b0;
            end else begin
                rbusy[p] = busy_r[ridx[p*IDX_W +: IDX_W]];
            end
        end
    end

    assign rsv_ready = rsv_accept_s;
    assign busy_cnt  = busy_cnt_r;

endmodule

// File: rtl/cv32e40p_register_file_sb.sv
// -----------------------------------------------------------------------------
// cv32e40p_register_file_sb
// Flip-flop register file with integrated write-back scoreboard.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   raddr_i / rdata_o        NUM_RPORTS combinational read ports
//   rbusy_o                  per read port: addressed register has a pending write
//   waddr_a_i/wdata_a_i/we_a_i  single-cycle write port A
//   waddr_b_i/wdata_b_i/we_b_i  long-latency write port B, also releases busy
//   rsv_valid_i/rsv_addr_i   reservation request, rsv_ready_o = accepted
//   flush_i                  clear all busy bits
//   busy_cnt_o               registered number of busy registers
// Storage, write arbitration (B beats A) and read/bypass muxes live here;
// busy tracking is in cv32e40p_regfile_scoreboard.
// -----------------------------------------------------------------------------
module cv32e40p_register_file_sb
    import cv32e40p_regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = REGFILE_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = 32'd32,
    parameter int unsigned FPU        = 32'd0,
    parameter int unsigned ZFINX      = 32'd0,
    parameter int unsigned NUM_RPORTS = 32'd3,
    parameter int unsigned BYPASS     = 32'd1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_RPORTS-1:0]            rbusy_o,
    input  logic [ADDR_WIDTH-1:0]            waddr_a_i,
    input  logic [DATA_WIDTH-1:0]            wdata_a_i,
    input  logic                             we_a_i,
    input  logic [ADDR_WIDTH-1:0]            waddr_b_i,
    input  logic [DATA_WIDTH-1:0]            wdata_b_i,
    input  logic                             we_b_i,
    input  logic                             rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]            rsv_addr_i,
    output logic                             rsv_ready_o,
    input  logic                             flush_i,
    output logic [ADDR_WIDTH:0]              busy_cnt_o
);

    localparam bit          FP_BANK   = (FPU != 32'd0) && (ZFINX == 32'd0);
    localparam bit          BYPASS_EN = (BYPASS != 32'd0);
    localparam int unsigned NUM_WORDS = total_words(ADDR_WIDTH, FP_BANK);
    localparam int unsigned IDX_W     = $clog2(NUM_WORDS);

    // Architectural address to flat storage index for this configuration.
    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'(flat_index(32'(addr), ADDR_WIDTH, FP_BANK));
    endfunction

    logic [DATA_WIDTH-1:0]       mem_r [NUM_WORDS];
    logic [IDX_W-1:0]            ridx_s [NUM_RPORTS];
    logic [NUM_RPORTS*IDX_W-1:0] ridx_flat_s;
    logic [IDX_W-1:0]            wa_idx_s;
    logic [IDX_W-1:0]            wb_idx_s;
    logic [IDX_W-1:0]            rsv_idx_s;

    assign wa_idx_s  = to_idx(waddr_a_i);
    assign wb_idx_s  = to_idx(waddr_b_i);
    assign rsv_idx_s = to_idx(rsv_addr_i);

    // Read address decode, kept both per port and packed for the scoreboard.
    always_comb begin
        ridx_flat_s = {(NUM_RPORTS*IDX_W){1'b0}};
        for (int p = 0; p < int'(NUM_RPORTS); p++) begin
            ridx_s[p]                       = to_idx(raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
            ridx_flat_s[p*IDX_W +: IDX_W]   = ridx_s[p];
        end
    end

    // Storage update: port B has priority over A on the same word; word 0 (x0)
    // is held at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 1; i < int'(NUM_WORDS); i++) begin
                if (we_b_i && (wb_idx_s == IDX_W'(i))) begin
                    mem_r[i] <= wdata_b_i;
                end else if (we_a_i && (wa_idx_s == IDX_W'(i))) begin
                    mem_r[i] <= wdata_a_i;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
            mem_r[0] <= {DATA_WIDTH{1'b0}};
        end
    end

    // Read muxes with optional same-cycle forwarding (B before A, never to x0).
    always_comb begin
        rdata_o = {(NUM_RPORTS*DATA_WIDTH){1'b0}};
        for (int p = 0; p < int'(NUM_RPORTS); p++) begin
            if (rst || (ridx_s[p] == {IDX_W{1'b0}})) begin
                rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end else if (BYPASS_EN && we_b_i && (wb_idx_s == ridx_s[p])) begin
                rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = wdata_b_i;
            end else if (BYPASS_EN && we_a_i && (wa_idx_s == ridx_s[p])) begin
                rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = wdata_a_i;
            end else begin
                rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = mem_r[ridx_s[p]];
            end
        end
    end

    cv32e40p_regfile_scoreboard #(
        .NUM_WORDS  (NUM_WORDS),
        .IDX_W      (IDX_W),
        .NUM_RPORTS (NUM_RPORTS),
        .CNT_W      (ADDR_WIDTH + 32'd1)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .ridx      (ridx_flat_s),
        .rbusy     (rbusy_o),
        .rsv_valid (rsv_valid_i),
        .rsv_idx   (rsv_idx_s),
        .rsv_ready (rsv_ready_o),
        .rel_valid (we_b_i),
        .rel_idx   (wb_idx_s),
        .flush     (flush_i),
        .busy_cnt  (busy_cnt_o)
    );

endmodule

// File: tb/tb_cv32e40p_register_file_sb.sv
// -----------------------------------------------------------------------------
// Bench for cv32e40p_register_file_sb. Two instances share one stimulus:
//   cfg 0 (dut_a): FPU=1, ZFINX=0, BYPASS=1 -> separate FP bank, forwarding
//   cfg 1 (dut_b): FPU=1, ZFINX=1, BYPASS=0 -> FP aliases integer bank
// A register/busy model per configuration predicts every output each cycle;
// directed literal expectations pin the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_cv32e40p_register_file_sb;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NP = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NP*AW-1:0]  raddr;
    logic [NP*DW-1:0]  rdata_a, rdata_b;
    logic [NP-1:0]     rbusy_a, rbusy_b;
    logic [AW-1:0]     waddr_a, waddr_b, rsv_addr;
    logic [DW-1:0]     wdata_a, wdata_b;
    logic              we_a, we_b, rsv_valid, flush;
    logic              rsv_ready_a, rsv_ready_b;
    logic [AW:0]       cnt_a, cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    // model state: contents and busy flags per architectural word, per config
    logic [31:0] m_mem  [2][64];
    logic [63:0] m_busy [2];

    cv32e40p_register_file_sb #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(1), .ZFINX(0), .NUM_RPORTS(3), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready_a),
        .flush_i(flush), .busy_cnt_o(cnt_a)
    );

    cv32e40p_register_file_sb #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(1), .ZFINX(1), .NUM_RPORTS(3), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready_b),
        .flush_i(flush), .busy_cnt_o(cnt_b)
    );

    // ---------------- model ----------------
    function automatic int widx(int c, logic [5:0] a);
        if (c == 0) return int'(a);
        return int'(a[4:0]);
    endfunction

    function automatic logic [31:0] exp_rdata(int c, logic [5:0] a);
        int w;
        w = widx(c, a);
        if (rst || w == 0) return 32'h0;
        if (c == 0 && we_b && widx(c, waddr_b) == w) return wdata_b;
        if (c == 0 && we_a && widx(c, waddr_a) == w) return wdata_a;
        return m_mem[c][w];
    endfunction

    function automatic logic exp_rbusy(int c, logic [5:0] a);
        if (rst) return 1'b0;
        return m_busy[c][widx(c, a)];
    endfunction

    function automatic logic exp_ready(int c);
        if (rst) return 1'b0;
        return rsv_valid && !m_busy[c][widx(c, rsv_addr)] && !flush;
    endfunction

    function automatic logic [31:0] exp_cnt(int c);
        if (rst) return 32'h0;
        return 32'($countones(m_busy[c]));
    endfunction

    task automatic model_update();
        logic rdy [2];
        int   wa, wb, wr;
        for (int c = 0; c < 2; c++) rdy[c] = exp_ready(c);
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int i = 0; i < 64; i++) m_mem[c][i] = 32'h0;
                m_busy[c] = 64'h0;
            end else begin
                wa = widx(c, waddr_a);
                wb = widx(c, waddr_b);
                wr = widx(c, rsv_addr);
                if (we_a && wa != 0) m_mem[c][wa] = wdata_a;
                if (we_b && wb != 0) m_mem[c][wb] = wdata_b;
                if (flush) begin
                    m_busy[c] = 64'h0;
                end else begin
                    if (we_b) m_busy[c][wb] = 1'b0;
                    if (rdy[c] && wr != 0) m_busy[c][wr] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_rdata(int c, int p);
        return (c == 0) ? rdata_a[p*DW +: DW] : rdata_b[p*DW +: DW];
    endfunction

    function automatic logic dut_rbusy(int c, int p);
        return (c == 0) ? rbusy_a[p] : rbusy_b[p];
    endfunction

    task automatic compare_all();
        logic [5:0] a;
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < NP; p++) begin
                a = raddr[p*AW +: AW];
                check($sformatf("rdata_cfg%0d_p%0d", c, p), dut_rdata(c, p), exp_rdata(c, a));
                check($sformatf("rbusy_cfg%0d_p%0d", c, p), 32'(dut_rbusy(c, p)), 32'(exp_rbusy(c, a)));
            end
            check($sformatf("rsv_ready_cfg%0d", c),
                  32'((c == 0) ? rsv_ready_a : rsv_ready_b), 32'(exp_ready(c)));
            check($sformatf("busy_cnt_cfg%0d", c),
                  32'((c == 0) ? cnt_a : cnt_b), exp_cnt(c));
        end
    endtask

    // one clock: compare on the falling edge, advance the model on the rising
    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        we_a = 1'b0; we_b = 1'b0; rsv_valid = 1'b0; flush = 1'b0;
        waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0; rsv_addr = '0;
    endtask
    task automatic wr_a(logic [5:0] a, logic [31:0] d);
        we_a = 1'b1; waddr_a = a; wdata_a = d;
    endtask
    task automatic wr_b(logic [5:0] a, logic [31:0] d);
        we_b = 1'b1; waddr_b = a; wdata_b = d;
    endtask
    task automatic rsv(logic [5:0] a);
        rsv_valid = 1'b1; rsv_addr = a;
    endtask
    task automatic rd(int p, logic [5:0] a);
        raddr[p*AW +: AW] = a;
    endtask

    initial begin
        rst = 1'b1;
        raddr = '0;
        idle();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 64; i++) m_mem[c][i] = 32'h0;
            m_busy[c] = 64'h0;
        end
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // 1. reset mid-operation
        wr_a(6'd5, 32'hDEADBEEF); rsv(6'd6); rd(0, 6'd5);
        cyc();
        idle(); #1;
        check("t1_x5_written", dut_rdata(0, 0), 32'hDEADBEEF);
        check("t1_cnt_before_rst", 32'(cnt_a), 32'd1);
        rst = 1'b1; wr_a(6'd5, 32'h1234); rsv(6'd7); #1;
        check("t1_rdata_in_rst", dut_rdata(0, 0), 32'h0);
        check("t1_cnt_in_rst", 32'(cnt_a), 32'h0);
        check("t1_ready_in_rst", 32'(rsv_ready_a), 32'h0);
        cyc();
        rst = 1'b0; idle(); #1;
        check("t1_x5_after_rst_a", dut_rdata(0, 0), 32'h0);
        check("t1_x5_after_rst_b", dut_rdata(1, 0), 32'h0);
        cyc();

        // 2. port conflict, B wins
        wr_a(6'd7, 32'h55); rd(0, 6'd7);
        cyc();
        idle(); wr_a(6'd7, 32'h11); wr_b(6'd7, 32'h22); #1;
        check("t2_bypass_b_wins", dut_rdata(0, 0), 32'h22);
        check("t2_nobypass_old", dut_rdata(1, 0), 32'h55);
        cyc();
        idle(); #1;
        check("t2_x7_a", dut_rdata(0, 0), 32'h22);
        check("t2_x7_b", dut_rdata(1, 0), 32'h22);
        cyc();

        // 3. x0 handling
        wr_a(6'd0, 32'hFFFFFFFF); wr_b(6'd0, 32'hFFFFFFFF); rsv(6'd0); rd(0, 6'd0); #1;
        check("t3_x0_bypass", dut_rdata(0, 0), 32'h0);
        check("t3_ready_x0_a", 32'(rsv_ready_a), 32'h1);
        check("t3_ready_x0_b", 32'(rsv_ready_b), 32'h1);
        cyc();
        idle(); #1;
        check("t3_cnt_a", 32'(cnt_a), 32'h0);
        check("t3_x0_b", dut_rdata(1, 0), 32'h0);
        cyc();

        // 4. scoreboard flow
        rsv(6'd3); rd(1, 6'd3); #1;
        check("t4_ready", 32'(rsv_ready_a), 32'h1);
        cyc();
        #1;
        check("t4_rereserve_a", 32'(rsv_ready_a), 32'h0);
        check("t4_rereserve_b", 32'(rsv_ready_b), 32'h0);
        check("t4_rbusy", 32'(rbusy_a[1]), 32'h1);
        check("t4_cnt", 32'(cnt_a), 32'h1);
        cyc();
        idle(); wr_b(6'd3, 32'h99); #1;
        check("t4_rbusy_same_cycle", 32'(rbusy_a[1]), 32'h1);
        check("t4_bypass_99", dut_rdata(0, 1), 32'h99);
        check("t4_nobypass_old", dut_rdata(1, 1), 32'h0);
        cyc();
        idle(); #1;
        check("t4_released", 32'(rbusy_a[1]), 32'h0);
        check("t4_cnt0", 32'(cnt_a), 32'h0);
        check("t4_x3_b", dut_rdata(1, 1), 32'h99);
        cyc();

        // 5. flush
        rsv(6'd1); cyc();
        rsv(6'd2); cyc();
        rsv(6'h24); cyc();
        idle(); #1;
        check("t5_cnt3_a", 32'(cnt_a), 32'd3);
        check("t5_cnt3_b", 32'(cnt_b), 32'd3);
        flush = 1'b1; rsv(6'd9); rd(2, 6'd9); #1;
        check("t5_flush_refuses", 32'(rsv_ready_a), 32'h0);
        cyc();
        idle(); #1;
        check("t5_cnt0", 32'(cnt_a), 32'h0);
        check("t5_x9_not_busy", 32'(rbusy_a[2]), 32'h0);
        cyc();

        // 6. bank aliasing
        wr_a(6'd1, 32'h77); cyc();
        wr_a(6'h21, 32'hA5); cyc();
        idle(); rd(0, 6'd1); rd(1, 6'h21); #1;
        check("t6_x1_kept_a", dut_rdata(0, 0), 32'h77);
        check("t6_f1_a", dut_rdata(0, 1), 32'hA5);
        check("t6_x1_alias_b", dut_rdata(1, 0), 32'hA5);
        cyc();

        // 7. f0 is a normal register with an FP bank, aliases x0 otherwise
        wr_b(6'h20, 32'h3C); cyc();
        idle(); rd(0, 6'h20); #1;
        check("t7_f0_a", dut_rdata(0, 0), 32'h3C);
        check("t7_f0_alias_b", dut_rdata(1, 0), 32'h0);
        rsv(6'h20); cyc();
        idle(); #1;
        check("t7_f0_busy_a", 32'(cnt_a), 32'h1);
        check("t7_f0_busy_b", 32'(cnt_b), 32'h0);
        wr_b(6'h20, 32'h3D); cyc();
        idle(); #1;
        check("t7_f0_released", 32'(cnt_a), 32'h0);
        cyc();

        // 8. sweep: B writes ascending, A writes descending, reservations chase B
        for (int i = 0; i < 64; i++) begin
            idle();
            wr_b(6'(i), 32'(i) * 32'h01010101 + 32'h1);
            wr_a(6'(63 - i), ~(32'(i) * 32'h00FF00FF));
            rsv(6'(i));
            rd(0, 6'(i)); rd(1, 6'(63 - i)); rd(2, 6'((i + 32) % 64));
            cyc();
        end
        idle();
        for (int i = 0; i < 64; i += 3) begin
            rd(0, 6'(i)); rd(1, 6'((i + 1) % 64)); rd(2, 6'((i + 2) % 64));
            cyc();
        end
        flush = 1'b1; cyc();
        idle(); cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
